// File: rtl/reg_array6_streamer.sv
// Streams a snapshot of a six-entry register bank (d1..d6) one word per
// valid/ready handshake, in ascending or descending index order.
module reg_array6_streamer #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic             abort,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(5);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q [6];
  logic [WIDTH-1:0] shadow_d [6];
  logic             dir_q, dir_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, busy_q, done_q;
  logic             capture;
  logic             lastWord;
  logic [IDX_W-1:0] nextIdx;
  logic [WIDTH-1:0] nextData;

  assign lastWord = dir_q ? (idx_q == '0) : (idx_q == LastIdx);
  assign nextIdx  = dir_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));

  // Explicit mux keeps the out-of-range index codes from reaching the shadow array.
  always_comb begin
    nextData = '0;
    case (nextIdx)
      IDX_W'(0): nextData = shadow_q[0];
      IDX_W'(1): nextData = shadow_q[1];
      IDX_W'(2): nextData = shadow_q[2];
      IDX_W'(3): nextData = shadow_q[3];
      IDX_W'(4): nextData = shadow_q[4];
      IDX_W'(5): nextData = shadow_q[5];
      default:   nextData = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    data_d  = data_q;
    capture = 1'b0;
    for (int i = 0; i < 6; i++) shadow_d[i] = shadow_q[i];

    case (state_q)
      IDLE: begin
        if (start && !abort) capture = 1'b1;
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (out_ready) begin
          if (lastWord) begin
            state_d = DONE;
          end else begin
            idx_d  = nextIdx;
            data_d = nextData;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (start) begin
          capture = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // The first word is taken straight from the inputs, since the shadow loads on the same edge.
    if (capture) begin
      shadow_d[0] = d1;
      shadow_d[1] = d2;
      shadow_d[2] = d3;
      shadow_d[3] = d4;
      shadow_d[4] = d5;
      shadow_d[5] = d6;
      dir_d       = dir;
      state_d     = STREAM;
      idx_d       = dir ? LastIdx : '0;
      data_d      = dir ? d6 : d1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= (state_d == STREAM);
      busy_q  <= (state_d == STREAM);
      done_q  <= (state_d == DONE);
      for (int i = 0; i < 6; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_array6_streamer.sv
// Directed self-checking bench for reg_array6_streamer: ordering, backpressure,
// snapshot isolation, abort, back-to-back restart and asynchronous reset.
module tb_reg_array6_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, dir, abort, outReady;
  logic [15:0] d1, d2, d3, d4, d5, d6;
  logic [15:0] outData;
  logic [3:0]  outIdx;
  logic        outValid, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_array6_streamer #(.WIDTH(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .out_data(outData), .out_idx(outIdx), .out_valid(outValid),
    .out_ready(outReady), .busy(busy), .done(done)
  );

  task automatic loadBank();
    d1 = 16'h0001; d2 = 16'h0002; d3 = 16'h0003;
    d4 = 16'h0004; d5 = 16'h0005; d6 = 16'h0006;
  endtask

  // Returns at the negedge where the first word should be visible.
  task automatic startStream(input logic direction);
    @(negedge clk);
    start = 1'b1;
    dir   = direction;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drainToIdle();
    outReady = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0; outReady = 1'b0;
    loadBank();
    repeat (2) @(negedge clk);
    checks++;
    if ({outData, outIdx, outValid, busy, done} !== 23'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got data=%h idx=%0d valid=%b busy=%b done=%b, want all 0",
               outData, outIdx, outValid, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ascending();
    loadBank();
    outReady = 1'b1;
    startStream(1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (outValid !== 1'b1 || outIdx !== 4'(i) || outData !== 16'(i + 1) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL asc_word%0d: got valid=%b idx=%0d data=%h busy=%b, want 1/%0d/%h/1",
                 i, outValid, outIdx, outData, busy, i, i + 1);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL asc_done: got done=%b valid=%b busy=%b, want 1/0/0", done, outValid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL asc_done_width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_descending_backpressure();
    int  expIdx;
    bit  finished;
    logic rdy;
    loadBank();
    outReady = 1'b0;
    startStream(1'b1);
    expIdx   = 5;
    finished = 1'b0;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      checks++;
      if (outValid !== 1'b1 || outIdx !== 4'(expIdx) || outData !== 16'(expIdx + 1) || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL desc_word cyc%0d: got valid=%b idx=%0d data=%h, want 1/%0d/%h",
                 cyc, outValid, outIdx, outData, expIdx, expIdx + 1);
      end
      rdy      = cyc[0];
      outReady = rdy;
      @(negedge clk);
      if (rdy) begin
        if (expIdx == 0) finished = 1'b1;
        else expIdx--;
      end
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("[TB] FAIL desc_timeout: got %0d words remaining, want 0", expIdx + 1);
    end
    checks++;
    if (done !== 1'b1 || outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL desc_done: got done=%b valid=%b, want 1/0", done, outValid);
    end
    drainToIdle();
  endtask

  task automatic test_snapshot();
    loadBank();
    outReady = 1'b1;
    startStream(1'b0);
    d3 = 16'hBEEF;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (outIdx !== 4'(i) || outData !== 16'(i + 1)) begin
        failures++;
        $display("[TB] FAIL snap_word%0d: got idx=%0d data=%h, want %0d/%h",
                 i, outIdx, outData, i, i + 1);
      end
      @(negedge clk);
    end
    @(negedge clk);
    startStream(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (outIdx !== 4'd2 || outData !== 16'hBEEF || outValid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL snap_reload: got idx=%0d data=%h valid=%b, want 2/beef/1",
               outIdx, outData, outValid);
    end
    drainToIdle();
  endtask

  task automatic test_abort();
    bit sawDone;
    loadBank();
    outReady = 1'b1;
    startStream(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (outIdx !== 4'd3) begin
      failures++;
      $display("[TB] FAIL abort_setup: got idx=%0d, want 3", outIdx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || outIdx !== 4'd0) begin
      failures++;
      $display("[TB] FAIL abort_stop: got valid=%b busy=%b done=%b idx=%0d, want 0/0/0/0",
               outValid, busy, done, outIdx);
    end
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || outValid === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      failures++;
      $display("[TB] FAIL abort_quiet: got done/valid activity=1, want 0");
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_abort_idle: got valid=%b busy=%b, want 0/0", outValid, busy);
    end
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_abort_hold: got valid=%b busy=%b done=%b, want 0/0/0",
               outValid, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    loadBank();
    outReady = 1'b1;
    startStream(1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_done: got done=%b, want 1", done);
    end
    start = 1'b1;
    dir   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outIdx !== 4'd5 || outData !== 16'h0006 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_restart: got valid=%b idx=%0d data=%h busy=%b done=%b, want 1/5/0006/1/0",
               outValid, outIdx, outData, busy, done);
    end
    drainToIdle();
  endtask

  task automatic test_reset_midstream();
    loadBank();
    outReady = 1'b1;
    startStream(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (outIdx !== 4'd2 || outValid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_setup: got idx=%0d valid=%b, want 2/1", outIdx, outValid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({outData, outIdx, outValid, busy, done} !== 23'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_async: got data=%h idx=%0d valid=%b busy=%b done=%b, want all 0",
               outData, outIdx, outValid, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    startStream(1'b0);
    checks++;
    if (outValid !== 1'b1 || outIdx !== 4'd0 || outData !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL rst_mid_restart: got valid=%b idx=%0d data=%h, want 1/0/0001",
               outValid, outIdx, outData);
    end
    drainToIdle();
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending_backpressure();
    test_snapshot();
    test_abort();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
